// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: data-memory handshake plus write-back register
// Optional feature macro: MEM_TIMEOUT_EN (abort a stalled access after TIMEOUT BUSY cycles)
module mem_wb_stage #(
  parameter int BASE_ADDR = 1024,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  input  logic [3:0]        Dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              freeze,
  output logic              writeBackEn,
  output logic [3:0]        Dest_wb,
  output logic [31:0]       Result_WB,
  output logic              mem_err
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               wb_en_q, wb_en_d;
  logic [3:0]         dest_q, dest_d;
  logic [31:0]        result_q, result_d;
  logic               timeout_hit;
  logic               is_mem_op;
  logic [31:0]        byte_off;

  assign is_mem_op = MEM_R_EN | MEM_W_EN;
  // Wraps modulo 2^32; the low two bits select a byte within the word and are dropped.
  assign byte_off  = ALU_Res - 32'(BASE_ADDR);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{byte_off[31:ADDR_W+2], byte_off[1:0]};

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (state_q == S_BUSY) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign mem_err     = err_q;

  // Count BUSY cycles (zero on the first BUSY cycle); the error flag is sticky until reset.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  assign mem_req     = (state_q == S_BUSY);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign writeBackEn = wb_en_q;
  assign Dest_wb     = dest_q;
  assign Result_WB   = result_q;

  // Next state, latched request fields, freeze and write-back register inputs.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    wb_en_d     = 1'b0;
    dest_d      = dest_q;
    result_d    = result_q;
    freeze      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_mem_op) begin
          freeze      = 1'b1;
          mem_addr_d  = byte_off[ADDR_W+1:2];
          mem_we_d    = MEM_W_EN & ~MEM_R_EN;
          mem_wdata_d = Val_Rm;
          state_d     = S_BUSY;
        end else begin
          wb_en_d  = WB_EN;
          dest_d   = Dest;
          result_d = ALU_Res;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d  = S_IDLE;
          wb_en_d  = WB_EN;
          dest_d   = Dest;
          result_d = mem_we_q ? ALU_Res : mem_rdata;
        end else if (timeout_hit) begin
          // A timed-out load retires with a zero result; a timed-out store is dropped.
          state_d = S_IDLE;
          if (!mem_we_q) begin
            wb_en_d  = WB_EN;
            dest_d   = Dest;
            result_d = 32'd0;
          end
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, memory request and write-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      dest_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wb_en_q     <= wb_en_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WB_EN = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] ALU_Res = '0, Val_Rm = '0, mem_rdata = '0;
  logic [3:0]  Dest = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, freeze, writeBackEn, mem_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, Result_WB;
  logic [3:0]  Dest_wb;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 15;

  mem_wb_stage #(.BASE_ADDR(1024), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding access at most, write-back slot per cycle.
  bit          m_busy = 0;
  int          m_waited = 0;
  logic [15:0] m_addr = '0;
  logic        m_we = 0, m_wbe = 0, m_err = 0;
  logic [31:0] m_wdata = '0, m_res = '0;
  logic [3:0]  m_dest = '0;

  function automatic bit m_abort();
    return m_busy && !mem_ready && TO_EN && (m_waited == TO - 1);
  endfunction

  initial begin
    bit          ab;
    logic [31:0] off;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("m_freeze", freeze, m_busy ? (!mem_ready && !m_abort()) : (MEM_R_EN | MEM_W_EN));
        check("m_mem_req", mem_req, m_busy);
        check("m_mem_we", mem_we, m_we);
        check("m_mem_addr", mem_addr, m_addr);
        check("m_mem_wdata", mem_wdata, m_wdata);
        check("m_wb_en", writeBackEn, m_wbe);
        check("m_dest_wb", Dest_wb, m_dest);
        check("m_result_wb", Result_WB, m_res);
        check("m_mem_err", mem_err, m_err);
      end
      @(posedge clk);
      ab = m_abort();
      if (rst) begin
        m_busy = 0; m_waited = 0; m_addr = '0; m_we = 0; m_wdata = '0;
        m_wbe = 0; m_dest = '0; m_res = '0; m_err = 0;
      end else if (!m_busy) begin
        if (MEM_R_EN || MEM_W_EN) begin
          off     = ALU_Res - 32'd1024;
          m_busy  = 1; m_waited = 0;
          m_addr  = 16'((off >> 2) & 32'hFFFF);
          m_we    = MEM_W_EN && !MEM_R_EN;
          m_wdata = Val_Rm;
          m_wbe   = 0;
        end else begin
          m_wbe = WB_EN; m_dest = Dest; m_res = ALU_Res;
        end
      end else if (mem_ready) begin
        m_busy = 0;
        m_wbe = WB_EN; m_dest = Dest; m_res = m_we ? ALU_Res : mem_rdata;
      end else if (ab) begin
        m_busy = 0; m_err = 1;
        if (m_we) m_wbe = 0;
        else begin m_wbe = WB_EN; m_dest = Dest; m_res = 32'd0; end
      end else begin
        m_waited++; m_wbe = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in();
    WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; ALU_Res = '0; Val_Rm = '0; Dest = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  logic [31:0] tab_alu [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
  logic [3:0]  tab_dst [3] = '{4'd15, 4'd0, 4'd8};
  logic        tab_wbe [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    int frz;
    cyc(); cyc();
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_en", writeBackEn, 0);
    check("rst_result", Result_WB, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_freeze", freeze, 0);
    rst = 0; chk_on = 1;

    // ADD
    cyc(); ALU_Res = 32'h5; Dest = 3; WB_EN = 1;
    @(negedge clk); check("add_freeze", freeze, 0);
    cyc(); clear_in();
    @(negedge clk);
    check("add_wb_en", writeBackEn, 1); check("add_dest", Dest_wb, 3); check("add_res", Result_WB, 5);

    // Non-memory table, each result one cycle after its inputs
    for (int i = 0; i < 3; i++) begin
      cyc(); ALU_Res = tab_alu[i]; Dest = tab_dst[i]; WB_EN = tab_wbe[i];
    end
    cyc(); clear_in();
    @(negedge clk);
    check("tab_wb_en", writeBackEn, 0); check("tab_res", Result_WB, 32'h8000_0000);

    // LDR with mem_ready 3 cycles after mem_req rises, then ADD back to back
    cyc(); ALU_Res = 1028; Dest = 7; WB_EN = 1; MEM_R_EN = 1;
    frz = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin mem_ready = 1; mem_rdata = 32'hCAFE_0001; end
      @(negedge clk);
      if (freeze) frz++;
      if (c >= 1) check("ldr_wb_frozen", writeBackEn, 0);
      if (c == 1) begin check("ldr_addr", mem_addr, 1); check("ldr_req", mem_req, 1); end
      cyc();
    end
    MEM_R_EN = 0; ALU_Res = 9; Dest = 2; WB_EN = 1; mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ldr_freeze_cycles", frz, 4);
    check("ldr_wb_en", writeBackEn, 1); check("ldr_dest", Dest_wb, 7);
    check("ldr_res", Result_WB, 32'hCAFE_0001); check("ldr_req_drop", mem_req, 0);
    cyc(); clear_in();
    @(negedge clk);
    check("b2b_wb_en", writeBackEn, 1); check("b2b_dest", Dest_wb, 2);
    check("b2b_res", Result_WB, 9); check("b2b_no_req", mem_req, 0);

    // STR with WB_EN=0
    cyc(); ALU_Res = 1032; Val_Rm = 32'h1234; MEM_W_EN = 1; WB_EN = 0; Dest = 5;
    cyc();
    @(negedge clk);
    check("str_we", mem_we, 1); check("str_addr", mem_addr, 2); check("str_wdata", mem_wdata, 32'h1234);
    cyc(); mem_ready = 1;
    @(negedge clk);
    check("str_hold_addr", mem_addr, 2); check("str_hold_wdata", mem_wdata, 32'h1234);
    check("str_freeze_rel", freeze, 0);
    cyc(); clear_in();
    @(negedge clk); check("str_no_wb", writeBackEn, 0); check("str_req_drop", mem_req, 0);

    // Both enables high -> load; address wraps below BASE_ADDR; immediate ready
    cyc(); ALU_Res = 32'h0; MEM_R_EN = 1; MEM_W_EN = 1; WB_EN = 1; Dest = 9;
    cyc(); mem_ready = 1; mem_rdata = 32'h5A5A;
    @(negedge clk);
    check("wrap_addr", mem_addr, 16'hFF00); check("rw_is_load", mem_we, 0); check("k0_freeze", freeze, 0);
    cyc(); clear_in();
    @(negedge clk); check("k0_res", Result_WB, 32'h5A5A); check("k0_dest", Dest_wb, 9);

    // Reset in the 2nd BUSY cycle
    cyc(); ALU_Res = 1040; Dest = 4; WB_EN = 1; MEM_R_EN = 1;
    cyc(); cyc(); rst = 1; clear_in();
    cyc(); rst = 0; mem_ready = 1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    check("rstm_req", mem_req, 0); check("rstm_freeze", freeze, 0);
    check("rstm_wb_en", writeBackEn, 0); check("rstm_res", Result_WB, 0); check("rstm_addr", mem_addr, 0);
    cyc(); clear_in();
    @(negedge clk); check("rstm_stray_wb", writeBackEn, 0); check("rstm_stray_res", Result_WB, 0);

`ifdef MEM_TIMEOUT_EN
    cyc(); ALU_Res = 1028; Dest = 6; WB_EN = 1; MEM_R_EN = 1;
    frz = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!freeze) break;
      frz++;
      cyc();
    end
    check("to_freeze_cycles", frz, 15);
    cyc(); clear_in();
    @(negedge clk);
    check("to_err", mem_err, 1); check("to_wb_en", writeBackEn, 1);
    check("to_dest", Dest_wb, 6); check("to_res", Result_WB, 0); check("to_req", mem_req, 0);
    cyc(); cyc(); cyc();
    @(negedge clk); check("to_err_sticky", mem_err, 1);
    rst = 1; cyc(); rst = 0;
    @(negedge clk); check("to_err_clr", mem_err, 0);
`endif

    cyc(); cyc();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
